// File: rtl/fifo_link_pkg.sv
// Shared constants for the FIFO-fed serial transmitter: FSM encodings,
// datapath widths and the frame-length helper.
package fifo_link_pkg;

  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned BIT_CNT_W = 8;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [STATE_W-1:0] ST_LATCH  = 3'd2;
  localparam logic [STATE_W-1:0] ST_START  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd4;
  localparam logic [STATE_W-1:0] ST_PARITY = 3'd5;
  localparam logic [STATE_W-1:0] ST_STOP   = 3'd6;

  // Start + 8 data + stop bits; the optional parity bit adds one more.
  localparam int unsigned FRAME_BITS_BASE = 10;

  // Clock cycles from START entry to STOP exit.
  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input int unsigned parity_en);
    return clks_per_bit * (FRAME_BITS_BASE + parity_en);
  endfunction

endpackage

// File: rtl/fifo_serial_tx_baud_tick_gen.sv
// Bit-period down-counter: loaded at frame start, reloads on each bit
// boundary and flags the last and next-to-last cycle of every bit.
module baud_tick_gen
  import fifo_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_tick_c,
  output logic o_pre_tick_c
);

  localparam logic [BIT_CNT_W-1:0] RELOAD = BIT_CNT_W'(CLKS_PER_BIT - 1);

  logic [BIT_CNT_W-1:0] r_count;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_run) begin
      if (r_count == '0) begin
        r_count <= RELOAD;
      end else begin
        r_count <= r_count - BIT_CNT_W'(1);
      end
    end else begin
      r_count <= '0;
    end
  end

  // Pre-tick lets the parent register a pulse aligned with the final cycle.
  assign o_tick_c     = i_run && (r_count == '0);
  assign o_pre_tick_c = i_run && (r_count == BIT_CNT_W'(1));

endmodule

// File: rtl/fifo_serial_tx.sv
// Pops one byte per frame from a registered-read FIFO and shifts it out
// LSB first as start / 8 data / optional even parity / stop.
module fifo_serial_tx
  import fifo_link_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 0
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done
);

  logic [STATE_W-1:0] r_state;
  logic [DATA_W-1:0]  r_shift;
  logic               r_parity;
  logic [IDX_W-1:0]   r_idx;
  logic               r_tx;
  logic               r_fifo_rd;
  logic               r_busy;
  logic               r_done;

  logic [STATE_W-1:0] w_state_nxt;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_parity_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_tx_nxt;
  logic               w_fifo_rd_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  logic               w_tick;
  logic               w_pre_tick;
  logic               w_baud_load;
  logic               w_baud_run;

  assign w_baud_load = (r_state == ST_LATCH);
  assign w_baud_run  = (r_state == ST_START) || (r_state == ST_DATA) ||
                       (r_state == ST_PARITY) || (r_state == ST_STOP);

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_tick_gen (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_load       (w_baud_load),
    .i_run        (w_baud_run),
    .o_tick_c     (w_tick),
    .o_pre_tick_c (w_pre_tick)
  );

  // State, datapath and output registers; outputs are precomputed from next state.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_idx     <= '0;
      r_tx      <= 1'b1;
      r_fifo_rd <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_idx     <= w_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_fifo_rd <= w_fifo_rd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_idx_nxt     = r_idx;
    w_tx_nxt      = 1'b1;
    w_fifo_rd_nxt = 1'b0;
    w_busy_nxt    = 1'b0;
    w_done_nxt    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_enable && !i_fifo_empty) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        // FIFO read data is valid this cycle, one cycle after the pop.
        w_state_nxt  = ST_START;
        w_shift_nxt  = i_fifo_data;
        w_parity_nxt = ^i_fifo_data;
        w_idx_nxt    = '0;
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt = ST_DATA;
          w_idx_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_idx == IDX_W'(7)) begin
            w_state_nxt = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    case (w_state_nxt)
      ST_START:  w_tx_nxt = 1'b0;
      ST_DATA:   w_tx_nxt = w_shift_nxt[0];
      ST_PARITY: w_tx_nxt = w_parity_nxt;
      default:   w_tx_nxt = 1'b1;
    endcase

    w_fifo_rd_nxt = (w_state_nxt == ST_FETCH);
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_done_nxt    = (r_state == ST_STOP) && w_pre_tick;
  end

  assign o_tx      = r_tx;
  assign o_fifo_rd = r_fifo_rd;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Directed bench: two transmitters (parity off / on) fed by behavioural
// registered-read FIFOs, checked cycle by cycle against hand-built frames.
module tb_fifo_serial_tx;

  localparam int C = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       en0, en1;
  logic       empty0, empty1;
  logic [7:0] fdata0, fdata1;
  logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(0)) u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_enable(en0), .i_fifo_empty(empty0),
    .i_fifo_data(fdata0), .o_fifo_rd(rd0), .o_tx(tx0), .o_busy(busy0), .o_done(done0)
  );

  fifo_serial_tx #(.CLKS_PER_BIT(C), .PARITY_EN(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_enable(en1), .i_fifo_empty(empty1),
    .i_fifo_data(fdata1), .o_fifo_rd(rd1), .o_tx(tx1), .o_busy(busy1), .o_done(done1)
  );

  // Behavioural FIFOs: data appears on the cycle after the read pulse.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
  assign empty0 = (wp0 == rp0);
  assign empty1 = (wp1 == rp1);

  always @(posedge clk) begin
    if (rd0) begin
      fdata0 <= mem0[rp0];
      rp0    <= rp0 + 1;
    end
    if (rd1) begin
      fdata1 <= mem1[rp1];
      rp1    <= rp1 + 1;
    end
  end

  int rdc0 = 0, rdc1 = 0, dnc0 = 0, dnc1 = 0;
  always @(posedge clk) begin
    if (rd0)   rdc0++;
    if (rd1)   rdc1++;
    if (done0) dnc0++;
    if (done1) dnc1++;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input logic [7:0] d);
    if (sel == 0) begin
      mem0[wp0] = d;
      wp0++;
    end else begin
      mem1[wp1] = d;
      wp1++;
    end
  endtask

  function automatic logic g_tx(input int sel);   return (sel != 0) ? tx1   : tx0;   endfunction
  function automatic logic g_busy(input int sel); return (sel != 0) ? busy1 : busy0; endfunction
  function automatic logic g_rd(input int sel);   return (sel != 0) ? rd1   : rd0;   endfunction
  function automatic logic g_done(input int sel); return (sel != 0) ? done1 : done0; endfunction

  task automatic chk_idle(input int sel, input string tag);
    chk({tag, ".tx"},   32'(g_tx(sel)),   32'd1);
    chk({tag, ".busy"}, 32'(g_busy(sel)), 32'd0);
    chk({tag, ".rd"},   32'(g_rd(sel)),   32'd0);
    chk({tag, ".done"}, 32'(g_done(sel)), 32'd0);
  endtask

  // Bounded wait for the first START cycle (busy with line low).
  task automatic wait_start(input int sel, input string tag, output bit found);
    found = 1'b0;
    for (int w = 0; w < 64 && !found; w++) begin
      @(negedge clk);
      if (g_busy(sel) && (g_tx(sel) == 1'b0)) found = 1'b1;
    end
    chk({tag, ".start_seen"}, 32'(found), 32'd1);
  endtask

  // seq[i] is the i-th transmitted bit; every cycle of the frame is checked.
  task automatic check_frame(input int sel, input logic [10:0] seq, input int nbits,
                             input string tag, input bit drop_en);
    bit found;
    int len;
    len = nbits * C;
    wait_start(sel, tag, found);
    if (!found) return;
    if (drop_en) en0 = 1'b0;
    for (int n = 1; n <= len; n++) begin
      if (n > 1) @(negedge clk);
      chk($sformatf("%s.tx@%0d", tag, n),   32'(g_tx(sel)),   32'(seq[(n - 1) / C]));
      chk($sformatf("%s.done@%0d", tag, n), 32'(g_done(sel)), 32'(n == len));
      chk($sformatf("%s.busy@%0d", tag, n), 32'(g_busy(sel)), 32'd1);
      chk($sformatf("%s.rd@%0d", tag, n),   32'(g_rd(sel)),   32'd0);
    end
  endtask

  initial begin
    int rd_base, dn_base;
    bit found;

    rst = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle(0, "reset0");
    chk_idle(1, "reset1");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_idle(0, $sformatf("empty_idle%0d", i));
    end
    chk("empty_idle.pops", 32'(rdc0), 32'd0);

    // Single frame 0xA5: 0,1,0,1,0,0,1,0,1,1.
    rd_base = rdc0;
    dn_base = dnc0;
    push(0, 8'hA5);
    check_frame(0, 11'b011_0100_1010, 10, "a5", 1'b0);
    @(negedge clk);
    chk_idle(0, "a5_after");
    chk("a5.pops",  32'(rdc0 - rd_base), 32'd1);
    chk("a5.dones", 32'(dnc0 - dn_base), 32'd1);

    // Back-to-back 0x01 then 0xFF with a three-cycle high gap.
    rd_base = rdc0;
    push(0, 8'h01);
    push(0, 8'hFF);
    check_frame(0, 11'b010_0000_0010, 10, "b2b_01", 1'b0);
    @(negedge clk);
    chk("gap.idle.tx",   32'(tx0),   32'd1);
    chk("gap.idle.busy", 32'(busy0), 32'd0);
    chk("gap.idle.rd",   32'(rd0),   32'd0);
    @(negedge clk);
    chk("gap.fetch.tx",   32'(tx0),   32'd1);
    chk("gap.fetch.busy", 32'(busy0), 32'd1);
    chk("gap.fetch.rd",   32'(rd0),   32'd1);
    @(negedge clk);
    chk("gap.latch.tx",   32'(tx0),   32'd1);
    chk("gap.latch.busy", 32'(busy0), 32'd1);
    chk("gap.latch.rd",   32'(rd0),   32'd0);
    check_frame(0, 11'b011_1111_1110, 10, "b2b_ff", 1'b0);
    @(negedge clk);
    chk_idle(0, "b2b_after");
    chk("b2b.pops", 32'(rdc0 - rd_base), 32'd2);

    // Reset during data bit 3 of 0x3C aborts; 0x81 follows.
    rd_base = rdc0;
    dn_base = dnc0;
    push(0, 8'h3C);
    push(0, 8'h81);
    wait_start(0, "abort", found);
    repeat (17) @(negedge clk);
    chk("abort.bit3.tx",   32'(tx0),   32'd1);
    chk("abort.bit3.busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle(0, "abort_rst");
    rst = 1'b0;
    chk("abort.dones", 32'(dnc0 - dn_base), 32'd0);
    check_frame(0, 11'b011_0000_0010, 10, "resume_81", 1'b0);
    @(negedge clk);
    chk("resume.pops",  32'(rdc0 - rd_base), 32'd2);
    chk("resume.dones", 32'(dnc0 - dn_base), 32'd1);

    // Enable dropped in START: 0x5A completes, 0x77 stays in the FIFO.
    rd_base = rdc0;
    push(0, 8'h5A);
    push(0, 8'h77);
    check_frame(0, 11'b010_1011_0100, 10, "en_drop", 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk_idle(0, $sformatf("disabled%0d", i));
    end
    chk("disabled.pops", 32'(rdc0 - rd_base), 32'd1);

    // Parity variant: 0xA5 has even weight, parity bit 0, 44-cycle frame.
    rd_base = rdc1;
    dn_base = dnc1;
    push(1, 8'hA5);
    check_frame(1, 11'b101_0100_1010, 11, "par_a5", 1'b0);
    @(negedge clk);
    chk_idle(1, "par_after");
    chk("par.pops",  32'(rdc1 - rd_base), 32'd1);
    chk("par.dones", 32'(dnc1 - dn_base), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
